// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: definitions shared by the memory arbiter and the LSU.
//   LEN_*           access length encodings (byte/half/word; 3..7 illegal)
//   arb_state_t     access-stage states IDLE / ACC_I / ACC_D
//   misaligned()    length/alignment legality check for an access
package mem_arbiter_pkg;

    localparam logic [2:0] LEN_BYTE = 3'd0;
    localparam logic [2:0] LEN_HALF = 3'd1;
    localparam logic [2:0] LEN_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACC_I = 2'd1,
        ACC_D = 2'd2
    } arb_state_t;

    // True when an access of length len at an address with low bits addr_lo
    // cannot be performed (misaligned, or an illegal length code).
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] len);
        logic bad;
        bad = 1'b0;
        if (len == LEN_WORD) begin
            bad = (addr_lo != 2'b00);
        end else if (len == LEN_HALF) begin
            bad = addr_lo[0];
        end else if (len != LEN_BYTE) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of the fetch port, load/store port and the memory
// side of the arbiter.
//   i_*    fetch port (word reads)
//   d_*    load/store port (byte/half/word, reads and writes)
//   mem_*  single-ported memory, combinational read data
//
// Handshake: a request transfers in the cycle where x_req and x_gnt are both
// high. While x_req is high and x_gnt is low the requester keeps x_req and all
// request fields stable. x_gnt is never high without x_req. The response is a
// one-cycle x_rvalid pulse two cycles after the transfer cycle; x_err and
// x_rdata are meaningful only while x_rvalid is high. There is no back-pressure
// on responses.
//
// Modports: slave = arbiter view, master = requesters plus memory.
interface mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [DATA_W-1:0] i_rdata;
    logic              i_err;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_len;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;
    logic              d_err;

    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wr_data;
    logic              mem_wr_enable;
    logic [2:0]        mem_write_length;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  i_req, i_addr,
        output i_gnt, i_rvalid, i_rdata, i_err,
        input  d_req, d_we, d_addr, d_wdata, d_len,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_address, mem_wr_data, mem_wr_enable, mem_write_length,
        input  mem_read_data
    );

    modport master (
        output i_req, i_addr,
        input  i_gnt, i_rvalid, i_rdata, i_err,
        output d_req, d_we, d_addr, d_wdata, d_len,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_address, mem_wr_data, mem_wr_enable, mem_write_length,
        output mem_read_data
    );

endinterface

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational grant selection between fetch and load/store.
//   i_req_i, d_req_i   pending requests
//   last_d_i           (MEM_ARB_ROUND_ROBIN_EN only) last grant went to D
//   i_gnt_o, d_gnt_o   one-hot-or-zero grant
// Build option MEM_ARB_ROUND_ROBIN_EN: when defined, conflicts alternate
// between the ports; otherwise D always wins a conflict.
module mem_arb_pick (
    input  logic i_req_i,
    input  logic d_req_i,
`ifdef MEM_ARB_ROUND_ROBIN_EN
    input  logic last_d_i,
`endif
    output logic i_gnt_o,
    output logic d_gnt_o
);

    always_comb begin
        i_gnt_o = 1'b0;
        d_gnt_o = 1'b0;
        if (i_req_i && d_req_i) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            // Give the conflict to whichever port did not win last time.
            if (last_d_i) begin
                i_gnt_o = 1'b1;
            end else begin
                d_gnt_o = 1'b1;
            end
`else
            d_gnt_o = 1'b1;
`endif
        end else begin
            i_gnt_o = i_req_i;
            d_gnt_o = d_req_i;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and access sequencer for the unified memory.
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   bus (slave)    fetch port, load/store port and memory side
//   dbg_state_o    current access-stage state
// One request is accepted per cycle into a one-entry access stage; the stage
// drives the memory for one cycle and a registered response follows.
// Illegal accesses pass through the stage flagged as errors and never write.
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin conflict resolution
// (default: load/store has fixed priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus,
    output arb_state_t   dbg_state_o
);

    arb_state_t        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [2:0]        len_q, len_d;
    logic              we_q, we_d;
    logic              err_q, err_d;

    logic              i_rvalid_q, i_rvalid_d, i_err_q, i_err_d;
    logic              d_rvalid_q, d_rvalid_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] rdata_sel;

    logic pick_i, pick_d, gnt_i, gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;
`endif

    mem_arb_pick u_pick (
        .i_req_i  (bus.i_req),
        .d_req_i  (bus.d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
        .last_d_i (last_d_q),
`endif
        .i_gnt_o  (pick_i),
        .d_gnt_o  (pick_d)
    );

    // Grants are forced low while reset is asserted.
    assign gnt_i     = pick_i & rst_n;
    assign gnt_d     = pick_d & rst_n;
    assign bus.i_gnt = gnt_i;
    assign bus.d_gnt = gnt_d;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_d_d = last_d_q;
        if (gnt_i) begin
            last_d_d = 1'b0;
        end else if (gnt_d) begin
            last_d_d = 1'b1;
        end
    end

    // Reset to "last = D" so the first conflict goes to fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_d_q <= 1'b1;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: the stage holds whatever was granted this cycle.
    always_comb begin
        state_d = IDLE;
        if (gnt_i) begin
            state_d = ACC_I;
        end else if (gnt_d) begin
            state_d = ACC_D;
        end
    end

    // Outputs towards memory, driven from the stage only while it is occupied.
    // rst_n gates the write enable so an asynchronous reset aborts a store.
    always_comb begin
        bus.mem_address      = '0;
        bus.mem_wr_data      = '0;
        bus.mem_write_length = LEN_BYTE;
        bus.mem_wr_enable    = 1'b0;
        if (state_q != IDLE) begin
            bus.mem_address      = addr_q;
            bus.mem_wr_data      = wdata_q;
            bus.mem_write_length = len_q;
            bus.mem_wr_enable    = we_q & ~err_q & rst_n;
        end
    end

    assign dbg_state_o = state_q;

    // Stage capture on grant; fetches are forced to word-length reads.
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        len_d   = len_q;
        we_d    = we_q;
        err_d   = err_q;
        if (gnt_i) begin
            addr_d  = bus.i_addr;
            wdata_d = '0;
            len_d   = LEN_WORD;
            we_d    = 1'b0;
            err_d   = misaligned(bus.i_addr[1:0], LEN_WORD);
        end else if (gnt_d) begin
            addr_d  = bus.d_addr;
            wdata_d = bus.d_wdata;
            len_d   = bus.d_len;
            we_d    = bus.d_we;
            err_d   = misaligned(bus.d_addr[1:0], bus.d_len);
        end
    end

    // Response capture at the edge that ends an access cycle. Stores and
    // errors return zero data.
    always_comb begin
        rdata_sel  = (!we_q && !err_q) ? bus.mem_read_data : '0;
        i_rvalid_d = (state_q == ACC_I);
        d_rvalid_d = (state_q == ACC_D);
        i_err_d    = i_err_q;
        i_rdata_d  = i_rdata_q;
        d_err_d    = d_err_q;
        d_rdata_d  = d_rdata_q;
        if (state_q == ACC_I) begin
            i_err_d   = err_q;
            i_rdata_d = rdata_sel;
        end
        if (state_q == ACC_D) begin
            d_err_d   = err_q;
            d_rdata_d = rdata_sel;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            wdata_q    <= '0;
            len_q      <= LEN_BYTE;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            i_rvalid_q <= 1'b0;
            i_err_q    <= 1'b0;
            i_rdata_q  <= '0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
        end else begin
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            len_q      <= len_d;
            we_q       <= we_d;
            err_q      <= err_d;
            i_rvalid_q <= i_rvalid_d;
            i_err_q    <= i_err_d;
            i_rdata_q  <= i_rdata_d;
            d_rvalid_q <= d_rvalid_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    assign bus.i_rvalid = i_rvalid_q;
    assign bus.i_err    = i_err_q;
    assign bus.i_rdata  = i_rdata_q;
    assign bus.d_rvalid = d_rvalid_q;
    assign bus.d_err    = d_err_q;
    assign bus.d_rdata  = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: bench for mem_arbiter with a byte-array memory and a
// transaction-level reference model (shadow memory + expected-response queue).
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
    arb_state_t dbg_state;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- memory environment ----------------
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       pl_copy = 1'b0;
    wire  [7:0] ra = {bus.mem_address[7:2], 2'b00};
    wire  [7:0] wa = bus.mem_address[7:0];

    assign bus.mem_read_data = {mem[ra + 8'd3], mem[ra + 8'd2], mem[ra + 8'd1], mem[ra]};

    always @(posedge clk) begin
        if (pl_copy) begin
            for (int k = 0; k < 256; k++) mem[k] <= ref_mem[k];
        end else if (bus.mem_wr_enable) begin
            mem[wa] <= bus.mem_wr_data[7:0];
            if (bus.mem_write_length != LEN_BYTE) mem[wa + 8'd1] <= bus.mem_wr_data[15:8];
            if (bus.mem_write_length == LEN_WORD) begin
                mem[wa + 8'd2] <= bus.mem_wr_data[23:16];
                mem[wa + 8'd3] <= bus.mem_wr_data[31:24];
            end
        end
    end

    // ---------------- scoreboard ----------------
    // entry: {vld, port(1=D), err, we, len[2:0], addr[31:0], wdata[31:0]}
    logic [70:0] exp_q[$];
    int checks = 0;
    int errors = 0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic rr_last_d = 1'b1;
`endif
    logic        mdl_gi, mdl_gd, obs_gd;
    logic [31:0] last_i_rdata, last_d_rdata;
    logic        last_d_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] w;
        logic [7:0]  b;
        b = {addr[7:2], 2'b00};
        for (int k = 0; k < 4; k++) w[8*k +: 8] = ref_mem[8'(b + k)];
        return w;
    endfunction

    // Asserts reset mid-cycle, checks reset values, then releases it.
    task automatic do_reset();
        #1;
        rst_n = 1'b0;
        bus.i_req = 1'b1;
        bus.d_req = 1'b1;
        #1;
        check("rst i_gnt", bus.i_gnt, 0);
        check("rst d_gnt", bus.d_gnt, 0);
        check("rst i_rvalid", bus.i_rvalid, 0);
        check("rst d_rvalid", bus.d_rvalid, 0);
        check("rst i_err", bus.i_err, 0);
        check("rst d_err", bus.d_err, 0);
        check("rst i_rdata", bus.i_rdata, 0);
        check("rst d_rdata", bus.d_rdata, 0);
        check("rst mem_wr_enable", bus.mem_wr_enable, 0);
        check("rst mem_address", bus.mem_address, 0);
        check("rst mem_wr_data", bus.mem_wr_data, 0);
        check("rst mem_write_length", 32'(bus.mem_write_length), 0);
        check("rst state", 32'(dbg_state), 32'(IDLE));
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.i_req = 1'b0;
        bus.d_req = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        exp_q.push_back('0);
        exp_q.push_back('0);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr_last_d = 1'b1;
`endif
    endtask

    // One clock cycle: drive request inputs, check responses, memory side
    // and grants against the model, then record this cycle's grant.
    task automatic cycle(input logic ir, input logic [31:0] ia, input logic dr, input logic dwe,
                         input logic [31:0] da, input logic [31:0] dwd, input logic [2:0] dl);
        logic [70:0] e, f, n;
        logic [31:0] exp_rd;
        logic        gi, gd, dbad;
        logic [7:0]  a;
        @(negedge clk);
        bus.i_req   = ir;
        bus.i_addr  = ia;
        bus.d_req   = dr;
        bus.d_we    = dwe;
        bus.d_addr  = da;
        bus.d_wdata = dwd;
        bus.d_len   = dl;
        #1;
        // response of the grant two cycles back; a legal store has committed
        e = exp_q.pop_front();
        exp_rd = '0;
        if (e[70] && !e[68]) begin
            a = e[39:32];
            if (e[67]) begin
                for (int k = 0; k < (1 << e[66:64]); k++) ref_mem[8'(a + k)] = e[8*k +: 8];
            end else begin
                exp_rd = ref_word(e[63:32]);
            end
        end
        check("i_rvalid", bus.i_rvalid, e[70] && !e[69]);
        check("d_rvalid", bus.d_rvalid, e[70] && e[69]);
        if (bus.i_rvalid) last_i_rdata = bus.i_rdata;
        if (bus.d_rvalid) begin
            last_d_rdata = bus.d_rdata;
            last_d_err   = bus.d_err;
        end
        if (e[70] && !e[69]) begin
            check("i_err", bus.i_err, e[68]);
            check("i_rdata", bus.i_rdata, exp_rd);
        end
        if (e[70] && e[69]) begin
            check("d_err", bus.d_err, e[68]);
            check("d_rdata", bus.d_rdata, exp_rd);
        end
        // access in flight this cycle
        f = exp_q[0];
        check("mem_wr_enable", bus.mem_wr_enable, f[70] && f[67] && !f[68]);
        check("mem_address", bus.mem_address, f[70] ? f[63:32] : 32'h0);
        if (f[70]) check("mem_write_length", 32'(bus.mem_write_length), 32'(f[66:64]));
        if (f[70] && f[69]) check("mem_wr_data", bus.mem_wr_data, f[31:0]);
        // grant rules
        if (ir && dr) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            gi = rr_last_d;
`else
            gi = 1'b0;
`endif
            gd = !gi;
        end else begin
            gi = ir;
            gd = dr;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        if (gi) rr_last_d = 1'b0;
        if (gd) rr_last_d = 1'b1;
`endif
        check("i_gnt", bus.i_gnt, gi);
        check("d_gnt", bus.d_gnt, gd);
        obs_gd = bus.d_gnt;
        mdl_gi = gi;
        mdl_gd = gd;
        dbad = (dl > 3'd2) || ((da % (32'd1 << dl)) != 0);
        if (gi) n = {1'b1, 1'b0, (ia % 4) != 0, 1'b0, LEN_WORD, ia, 32'h0};
        else if (gd) n = {1'b1, 1'b1, dbad, dwe, dl, da, dwd};
        else n = '0;
        exp_q.push_back(n);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, LEN_BYTE);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  gpat, gexp;
        logic [31:0] old_w, ia, da, dwd;
        logic        pi, pd, dwe;
        logic [2:0]  dl;

        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_len = '0;
        last_i_rdata = '0; last_d_rdata = '0; last_d_err = 1'b0;
        for (int k = 0; k < 256; k++) ref_mem[k] = 8'($urandom);
        {ref_mem[11], ref_mem[10], ref_mem[9], ref_mem[8]} = 32'h12345678;
        pl_copy = 1'b1;
        do_reset();
        pl_copy = 1'b0;

        // single fetch
        cycle(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, LEN_BYTE);
        idle(2);
        check("fetch 0x8", last_i_rdata, 32'h12345678);

        // store then load to the same word
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h14, 32'h89ABCDEF, LEN_WORD);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h14, 32'h0, LEN_WORD);
        check("store ack rdata", last_d_rdata, 32'h0);
        idle(2);
        check("load after store", last_d_rdata, 32'h89ABCDEF);

        // byte stores then word load
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h20, 32'hEF, LEN_BYTE);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h21, 32'hAD, LEN_BYTE);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h22, 32'hBD, LEN_BYTE);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h23, 32'hAB, LEN_BYTE);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h20, 32'h0, LEN_WORD);
        idle(2);
        check("byte stores word", last_d_rdata, 32'hABBDADEF);

        // conflict for four cycles
        gpat = '0;
        for (int k = 0; k < 4; k++) begin
            cycle(1'b1, 32'h40, 1'b1, 1'b0, 32'h44, 32'h0, LEN_WORD);
            gpat[k] = obs_gd;
        end
`ifdef MEM_ARB_ROUND_ROBIN_EN
        gexp = 4'b1010;
`else
        gexp = 4'b1111;
`endif
        check("conflict d_gnt pattern", 32'(gpat), 32'(gexp));
        idle(2);

        // misaligned word store
        old_w = ref_word(32'h24);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h25, 32'hDEADBEEF, LEN_WORD);
        idle(2);
        check("misaligned d_err", 32'(last_d_err), 1);
        check("misaligned rdata", last_d_rdata, 32'h0);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h24, 32'h0, LEN_WORD);
        idle(2);
        check("word 0x24 unchanged", last_d_rdata, old_w);

        // reset during the access cycle of a store
        old_w = ref_word(32'h30);
        cycle(1'b0, 32'h0, 1'b1, 1'b1, 32'h30, 32'hCAFEF00D, LEN_WORD);
        idle(1);
        do_reset();
        idle(2);
        cycle(1'b0, 32'h0, 1'b1, 1'b0, 32'h30, 32'h0, LEN_WORD);
        idle(2);
        check("word 0x30 after reset", last_d_rdata, old_w);

        // randomized traffic; each port holds its request until granted
        pi = 1'b0; pd = 1'b0; ia = '0; da = '0; dwd = '0; dwe = 1'b0; dl = '0;
        for (int c = 0; c < 500; c++) begin
            if (!pi) begin
                pi = ($urandom_range(0, 2) != 0);
                ia = $urandom_range(0, 63) * 4;
                if ($urandom_range(0, 7) == 0) ia = ia + $urandom_range(1, 3);
            end
            if (!pd) begin
                pd  = ($urandom_range(0, 2) != 0);
                dwe = 1'($urandom_range(0, 1));
                dl  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                da  = $urandom_range(0, 63) * 4;
                if ($urandom_range(0, 3) == 0) da = da + $urandom_range(1, 3);
                dwd = $urandom;
            end
            cycle(pi, ia, pd, dwe, da, dwd, dl);
            if (mdl_gi) pi = 1'b0;
            if (mdl_gd) pd = 1'b0;
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and access sequencer in front of the single-ported unified `Memory` of the core. It shares the memory between the instruction-fetch port (word reads only) and the load/store port (byte/half/word reads and writes). It registers each accepted request into a one-entry access stage, drives the memory from that stage, and returns a registered response one cycle later. It also rejects misaligned or illegal-length accesses without touching memory.

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width; fixed at 32 for this core.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req`  in  1  fetch request; held until `i_gnt`.
- `i_addr`  in  ADDR_W  fetch address.
- `i_gnt`  out  1  fetch request accepted this cycle (combinational).
- `i_rvalid`  out  1  fetch response valid (one-cycle pulse).
- `i_rdata`  out  DATA_W  fetched word.
- `i_err`  out  1  fetch response is a misalignment error; qualified by `i_rvalid`.
- `d_req`  in  1  load/store request; held, with all fields stable, until `d_gnt`.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  ADDR_W  load/store address.
- `d_wdata`  in  DATA_W  store data, LSB-aligned.
- `d_len`  in  3  0 = byte, 1 = half, 2 = word, 3–7 illegal.
- `d_gnt`, `d_rvalid`, `d_rdata`, `d_err`  out  1/1/DATA_W/1  same meaning as the fetch port.
- `mem_address`  out  ADDR_W  to `Memory.address`.
- `mem_wr_data`  out  DATA_W  to `Memory.wr_data`.
- `mem_wr_enable`  out  1  to `Memory.wr_enable`.
- `mem_write_length`  out  3  to `Memory.write_length`.
- `mem_read_data`  in  DATA_W  from `Memory.read_data`; combinational read.

## Operation
- Access-stage states: IDLE, ACC_I, ACC_D.
  - Any state moves to ACC_I or ACC_D when a request is granted.
  - Any state moves to IDLE when no request is granted.
- A request is accepted every cycle, so throughput is one access per cycle, sustained.
- Grant rules:
  - Only `i_req`: grant I.
  - Only `d_req`: grant D.
  - Both: resolved by the policy in Configuration.
  - At most one `*_gnt` is high per cycle. A grant is never given without the matching request.
- On grant, the following are latched into the access stage at the rising edge:
  - Address.
  - Write data.
  - Length: word, forced for I.
  - Write flag: 0, forced for I.
  - Error flag.
- Error conditions:
  - Fetch: `i_addr[1:0] != 0`.
  - Load/store: `d_len == 2` with `d_addr[1:0] != 0`; `d_len == 1` with `d_addr[0] == 1`; `d_len >= 3`.
- In ACC_x:
  - `mem_*` are driven from the stage.
  - `mem_wr_enable = stage_we & ~stage_err & rst_n`.
  - In IDLE, `mem_wr_enable = 0` and `mem_address = 0`.
- Response capture, at the rising edge that ends ACC_x:
  - `x_rvalid <= 1`.
  - `x_err <= stage_err`.
  - `x_rdata <= (load && !err) ? mem_read_data : 0`.
- Stores and errors return `rdata = 0`. Stores produce an ack via `d_rvalid`.
- Loads return the raw aligned word from `mem_read_data`. Extension of sub-word loads is done by the LSU, not here.

## Timing
- Cycle N: request is high and `x_gnt` is high. The requester may change its fields from N+1 onward.
- Cycle N+1: ACC_x; memory is addressed. A store commits at the rising edge ending N+1.
- Cycle N+2: `x_rvalid` is high for exactly one cycle.
- Back-to-back grants give back-to-back `rvalid` pulses, in grant order.
- A store followed by a load to the same address in the next grant returns the new data. The load's ACC cycle follows the store's commit edge.
- Reset values:
  - All `*_gnt`, `*_rvalid`, `*_err`, `mem_wr_enable`: 0.
  - `*_rdata`, `mem_address`, `mem_wr_data`, `mem_write_length`: 0.
  - State: IDLE.
  - Round-robin pointer: "last = D".
- Reset asserted mid-ACC:
  - `mem_wr_enable` drops asynchronously, so no write occurs.
  - A pending response is discarded and no `rvalid` is issued after release.
- `*_gnt` are masked by `rst_n` (0 while reset is asserted).

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN`:
  - Defined: on conflict, grant the port not granted at the most recent conflict-or-grant. The pointer updates on every grant.
  - Undefined: fixed priority, D always wins over I, and the pointer logic is not compiled.

## Structure
- Shared package (common definitions header):
  - `LEN_BYTE = 3'd0`, `LEN_HALF = 3'd1`, `LEN_WORD = 3'd2`.
  - State encodings IDLE/ACC_I/ACC_D.
  - A misalignment check function reused by the LSU.
- One natural sub-module, `mem_arb_pick`: combinational grant selection from `i_req`, `d_req` and the pointer. Its internals change with the macro.

## Test plan
- Single fetch: `i_req`, `i_addr = 0x8`, memory word `0x12345678` → `i_gnt` at N, `i_rvalid` with `i_rdata = 0x12345678` at N+2, `i_err = 0`.
- Store then load: D word store `0x89ABCDEF` to `0x14`, then D load `0x14` → store ack at N+2 with `d_rdata = 0`; load `d_rdata = 0x89ABCDEF` at N+3.
- Byte stores: four `d_len = 0` stores to `0x20..0x23` with LSBs `EF, AD, BD, AB`, then a word load of `0x20` → `0xABBDADEF`.
- Conflict, both ports requesting for 4 cycles:
  - Round robin: grants I, D, I, D.
  - Without macro: D, D, D, D.
- Misaligned: word store `0xDEADBEEF` to `0x25` → `d_err = 1`, `d_rdata = 0`, `mem_wr_enable` never high. A word load of `0x24` is unchanged.
- Reset mid-store: drop `rst_n` during ACC_D of a store to `0x30` → memory at `0x30` unchanged, no `d_rvalid` after release, all outputs 0.
